decoder_2to4_hold: RTL and testbench

Registered 2-to-4 decoder with a hold timer. It takes an encoded code and valid pair, in the same D/Y/V style our 4-to-2 priority encoder produces, and drives a one-hot output. Each decoded result is held for a programmable number of cycles, so single-cycle events remain visible on Basys 3 LEDs. It sits downstream of the priority encoder and also serves as its loopback checker in board tests.

---
 rtl/decoder_pkg.sv | 18 +
 rtl/decoder_2to4_hold_hold_timer.sv | 32 +++
 rtl/decoder_2to4_hold.sv | 132 +++++++++++++
 tb/tb_decoder_2to4_hold.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/decoder_pkg.sv
// Shared types and helpers for the registered 2-to-4 decoder with hold timer.
package decoder_pkg;

   // FSM states: waiting for a code, showing a code, forced off-cycle.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HOLD = 2'd1,
      GAP  = 2'd2
   } state_t;

   localparam logic [3:0] ONEHOT_ZERO = 4'b0000;

   // Binary code to one-hot; the result always has exactly one bit set.
   function automatic logic [3:0] decode2to4(input logic [1:0] code);
      return 4'b0001 << code;
   endfunction

endpackage

// File: rtl/decoder_2to4_hold_hold_timer.sv
// Loadable down-counter that times how long a decoded code stays visible.
// Counts down while dec is high and saturates at zero; zero reflects the
// registered count.
module hold_timer #(
   parameter int unsigned W = 20
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic         dec,
   input  logic [W-1:0] load_val,
   output logic         zero
);

   logic [W-1:0] cnt_r;

   // Count register: load has priority over decrement, saturate at zero.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_r <= {W{1'b0}};
      end else if (load) begin
         cnt_r <= load_val;
      end else if (dec && (cnt_r != {W{1'b0}})) begin
         cnt_r <= cnt_r - {{(W-1){1'b0}}, 1'b1};
      end else begin
         cnt_r <= cnt_r;
      end
   end

   assign zero = (cnt_r == {W{1'b0}});

endmodule

// File: rtl/decoder_2to4_hold.sv
// Registered 2-to-4 decoder that holds each accepted code on D for
// HOLD_CYCLES cycles, then forces one off-cycle before accepting again.
// Optional macro DEC_RETRIGGER_EN: a valid code during HOLD restarts the
// hold with the new code (ready is then also high in HOLD).
module decoder_2to4_hold
   import decoder_pkg::*;
#(
   parameter int unsigned HOLD_CYCLES = 1_000_000,
   parameter int unsigned CNT_W       = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [1:0]       Y,
   input  logic             V,
   output logic             ready,
   output logic [3:0]       D,
   output logic             busy,
   output logic [CNT_W-1:0] evt_cnt
);

   localparam int unsigned   TW     = $clog2(HOLD_CYCLES + 1);
   localparam logic [TW-1:0] RELOAD = TW'(HOLD_CYCLES - 1);

   state_t           state_r;
   state_t           state_s;
   logic [3:0]       d_r;
   logic [3:0]       d_s;
   logic             ready_r;
   logic             ready_s;
   logic             busy_r;
   logic             busy_s;
   logic [CNT_W-1:0] evt_cnt_r;
   logic             accept_s;
   logic             dec_s;
   logic             zero_s;

   hold_timer #(
      .W (TW)
   ) u_hold_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (accept_s),
      .dec      (dec_s),
      .load_val (RELOAD),
      .zero     (zero_s)
   );

   // Next state, accept/decrement strobes and next values of the output flops.
   always_comb begin
      state_s  = state_r;
      accept_s = 1'b0;
      dec_s    = 1'b0;
      case (state_r)
         IDLE: begin
            if (V) begin
               accept_s = 1'b1;
               state_s  = HOLD;
            end else begin
               state_s  = IDLE;
            end
         end
         HOLD: begin
`ifdef DEC_RETRIGGER_EN
            if (V) begin
               accept_s = 1'b1;
               state_s  = HOLD;
            end else if (zero_s) begin
               state_s  = GAP;
            end else begin
               dec_s    = 1'b1;
               state_s  = HOLD;
            end
`else
            if (zero_s) begin
               state_s  = GAP;
            end else begin
               dec_s    = 1'b1;
               state_s  = HOLD;
            end
`endif
         end
         GAP: begin
            state_s = IDLE;
         end
         default: begin
            state_s = IDLE;
         end
      endcase

      if (accept_s) begin
         d_s = decode2to4(Y);
      end else if (state_s == HOLD) begin
         d_s = d_r;
      end else begin
         d_s = ONEHOT_ZERO;
      end

`ifdef DEC_RETRIGGER_EN
      ready_s = (state_s == IDLE) || (state_s == HOLD);
`else
      ready_s = (state_s == IDLE);
`endif
      busy_s = (state_s != IDLE);
   end

   // State and output registers so every output comes straight from a flop.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r   <= IDLE;
         d_r       <= ONEHOT_ZERO;
         ready_r   <= 1'b1;
         busy_r    <= 1'b0;
         evt_cnt_r <= {CNT_W{1'b0}};
      end else begin
         state_r <= state_s;
         d_r     <= d_s;
         ready_r <= ready_s;
         busy_r  <= busy_s;
         if (accept_s) begin
            evt_cnt_r <= evt_cnt_r + CNT_W'(1);
         end else begin
            evt_cnt_r <= evt_cnt_r;
         end
      end
   end

   assign D       = d_r;
   assign ready   = ready_r;
   assign busy    = busy_r;
   assign evt_cnt = evt_cnt_r;

endmodule

// File: tb/tb_decoder_2to4_hold.sv
// Directed bench for decoder_2to4_hold with HOLD_CYCLES = 4. Two instances
// share the stimulus: one with an 8-bit event counter, one with a 2-bit
// counter to exercise wrap-around.
module tb_decoder_2to4_hold;

`ifdef DEC_RETRIGGER_EN
   localparam bit RH = 1'b1;
`else
   localparam bit RH = 1'b0;
`endif

   typedef struct {
      logic       rst_n;
      logic       v;
      logic [1:0] y;
      logic [3:0] d;
      logic       rdy;
      logic       busy;
      int         cnt;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [1:0] y;
   logic       v;
   logic       ready_a, busy_a, ready_b, busy_b;
   logic [3:0] d_a, d_b;
   logic [7:0] cnt_a;
   logic [1:0] cnt_b;

   vec_t vq[$];
   int   evt;
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   decoder_2to4_hold #(.HOLD_CYCLES(4), .CNT_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .Y(y), .V(v),
      .ready(ready_a), .D(d_a), .busy(busy_a), .evt_cnt(cnt_a)
   );

   decoder_2to4_hold #(.HOLD_CYCLES(4), .CNT_W(2)) dut_w (
      .clk(clk), .rst_n(rst_n), .Y(y), .V(v),
      .ready(ready_b), .D(d_b), .busy(busy_b), .evt_cnt(cnt_b)
   );

   task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s row=%0d got=%0h want=%0h", name, idx, act, exp);
      end
   endtask

   task automatic push(input logic r, input logic vv, input logic [1:0] yy,
                       input logic [3:0] dd, input logic rr, input logic bb, input int cc);
      vec_t e;
      e.rst_n = r; e.v = vv; e.y = yy; e.d = dd; e.rdy = rr; e.busy = bb; e.cnt = cc;
      vq.push_back(e);
   endtask

   // One-cycle V pulse from IDLE: 4 cycles of D, one GAP cycle, back to IDLE.
   task automatic pulse(input logic [1:0] yy, input logic [3:0] oh);
      evt++;
      push(1'b1, 1'b1, yy, oh, RH, 1'b1, evt);
      for (int k = 0; k < 3; k++) push(1'b1, 1'b0, ~yy, oh, RH, 1'b1, evt);
      push(1'b1, 1'b0, yy, 4'b0000, 1'b0, 1'b1, evt);
      push(1'b1, 1'b0, yy, 4'b0000, 1'b1, 1'b0, evt);
   endtask

   initial begin
      logic [3:0] oh_tab [4];
      int         n;
      oh_tab[0] = 4'b0001; oh_tab[1] = 4'b0010; oh_tab[2] = 4'b0100; oh_tab[3] = 4'b1000;
      rst_n = 1'b0; v = 1'b1; y = 2'd3;
      evt = 0;

      // Reset with V asserted
      push(1'b0, 1'b1, 2'd3, 4'b0000, 1'b1, 1'b0, 0);
      push(1'b0, 1'b1, 2'd3, 4'b0000, 1'b1, 1'b0, 0);
      // Single event, Y = 2
      pulse(2'd2, 4'b0100);
      // Sweep 0..3
      for (int k = 0; k < 4; k++) pulse(2'(k), oh_tab[k]);
      // Continuous V with Y = 1 for 20 cycles, then drain
`ifdef DEC_RETRIGGER_EN
      for (int i = 0; i < 20; i++) begin
         evt++;
         push(1'b1, 1'b1, 2'd1, 4'b0010, 1'b1, 1'b1, evt);
      end
      for (int i = 0; i < 3; i++) push(1'b1, 1'b0, 2'd1, 4'b0010, 1'b1, 1'b1, evt);
      push(1'b1, 1'b0, 2'd1, 4'b0000, 1'b0, 1'b1, evt);
`else
      for (int i = 0; i < 24; i++) begin
         int ph;
         ph = i % 6;
         if (ph == 0) evt++;
         push(1'b1, (i < 20), 2'd1, (ph < 4) ? 4'b0010 : 4'b0000,
              (ph == 5), (ph != 5), evt);
      end
`endif
      push(1'b1, 1'b0, 2'd1, 4'b0000, 1'b1, 1'b0, evt);
      // Mid-HOLD V with Y = 0 on the edge ending the 2nd HOLD cycle
      evt++;
      push(1'b1, 1'b1, 2'd3, 4'b1000, RH, 1'b1, evt);
      push(1'b1, 1'b0, 2'd3, 4'b1000, RH, 1'b1, evt);
`ifdef DEC_RETRIGGER_EN
      evt++;
      push(1'b1, 1'b1, 2'd0, 4'b0001, 1'b1, 1'b1, evt);
      for (int k = 0; k < 3; k++) push(1'b1, 1'b0, 2'd2, 4'b0001, 1'b1, 1'b1, evt);
`else
      push(1'b1, 1'b1, 2'd0, 4'b1000, 1'b0, 1'b1, evt);
      push(1'b1, 1'b0, 2'd2, 4'b1000, 1'b0, 1'b1, evt);
`endif
      push(1'b1, 1'b0, 2'd0, 4'b0000, 1'b0, 1'b1, evt);
      push(1'b1, 1'b0, 2'd0, 4'b0000, 1'b1, 1'b0, evt);
      // Reset on the edge ending the 3rd HOLD cycle
      evt++;
      push(1'b1, 1'b1, 2'd1, 4'b0010, RH, 1'b1, evt);
      push(1'b1, 1'b0, 2'd1, 4'b0010, RH, 1'b1, evt);
      push(1'b1, 1'b0, 2'd1, 4'b0010, RH, 1'b1, evt);
      push(1'b0, 1'b1, 2'd2, 4'b0000, 1'b1, 1'b0, 0);
      evt = 0;
      // Five events right after reset release: 2-bit counter wraps to 1
      for (int k = 0; k < 5; k++) pulse(2'(k % 4), oh_tab[k % 4]);

      // Apply the table
      for (int i = 0; i < vq.size(); i++) begin
         rst_n = vq[i].rst_n; v = vq[i].v; y = vq[i].y;
         @(posedge clk); #1;
         check("D",       i, 32'(d_a),     32'(vq[i].d));
         check("ready",   i, 32'(ready_a), 32'(vq[i].rdy));
         check("busy",    i, 32'(busy_a),  32'(vq[i].busy));
         check("evt_cnt", i, 32'(cnt_a),   32'(vq[i].cnt & 255));
         check("evt_w2",  i, 32'(cnt_b),   32'(vq[i].cnt & 3));
         check("D_w2",    i, 32'(d_b),     32'(vq[i].d));
      end

      // Hand sequence: ready/busy return HOLD_CYCLES+1 edges after acceptance
      rst_n = 1'b1; v = 1'b1; y = 2'd3;
      @(posedge clk); #1;
      v = 1'b0; y = 2'd0;
      check("seq_D",   1000, 32'(d_a),   32'h8);
      check("seq_cnt", 1000, 32'(cnt_a), 32'd6);
      n = 0;
      while (busy_a && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      check("seq_busy_len", 1001, 32'(n), 32'd5);
      check("seq_ready",    1002, 32'(ready_a), 32'd1);
      check("seq_D_off",    1003, 32'(d_a), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
